tile_game_ctrl: RTL and testbench

//  Game-flow controller for Piano Tiles; drives the wait counter from the upstream side.
//  - Raises wait_go to start a wait and advances the tile grid one row on each wait_done.
//  - Judges player key presses against the bottom row.
//  - Owns the 24-bit score that feeds the wait counter's Q input, so the game speeds up as the score rises.

---
 rtl/tile_game_ctrl_if.sv | 21 ++
 rtl/tile_game_ctrl.sv | 122 ++++++++++++
 tb/tb_tile_game_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_game_ctrl_if.sv
// Link between the game controller and the wait counter.
// The controller owns wait_go and the score; the counter answers with wait_done.
interface tile_game_ctrl_if #(
  parameter int SCORE_W = 24
);
  logic               wait_go;
  logic               wait_done;
  logic [SCORE_W-1:0] score;

  modport master (
    output wait_go,
    output score,
    input  wait_done
  );

  modport slave (
    input  wait_go,
    input  score,
    output wait_done
  );
endinterface

// File: rtl/tile_game_ctrl.sv
// Piano Tiles game flow: paces rows with the wait counter,
// judges key presses against the bottom row and keeps the score.
module tile_game_ctrl #(
  parameter int NUM_ROWS = 4,
  parameter int SCORE_W  = 24
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [3:0]            key,
  input  logic [1:0]            rand_lane,
  tile_game_ctrl_if.master      wc,
  output logic [4*NUM_ROWS-1:0] grid,
  output logic                  game_over
);

  localparam int GW = 4 * NUM_ROWS;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SHIFT,
    OVER
  } state_t;

  state_t             state;
  state_t             nxt;
  logic [3:0]         key_prev;
  logic [3:0]         press;
  logic [3:0]         bottom;
  logic [3:0]         lane_oh;
  logic [SCORE_W-1:0] score_q;
  logic [GW-1:0]      grid_q;
  logic               hit;
  logic               bad;
  logic               init;

  assign press   = key & ~key_prev;
  assign bottom  = grid_q[GW-1 -: 4];
  assign lane_oh = 4'b0001 << rand_lane;

  // A valid hit is a single new press exactly on the bottom tile.
  assign hit = (state == WAIT)
             && (|bottom)
             && $onehot(press)
             && (press == bottom);

  assign bad = (state == WAIT)
             && (|bottom)
             && (|press)
             && !hit;

  assign init = (state == IDLE || state == OVER)
              && start;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) nxt = WAIT;
      end
      WAIT: begin
        if (bad)            nxt = OVER;
        else if (wc.wait_done) nxt = SHIFT;
      end
      SHIFT: begin
        if (|bottom) nxt = OVER;
        else         nxt = WAIT;
      end
      OVER: begin
        if (start) nxt = WAIT;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    wc.wait_go = 1'b0;
    game_over  = 1'b0;
    unique case (state)
      WAIT:    wc.wait_go = 1'b1;
      OVER:    game_over  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_prev <= '0;
      score_q  <= '0;
      grid_q   <= '0;
    end else begin
      key_prev <= key;
      unique case (1'b1)
        init: begin
          score_q <= '0;
          grid_q  <= '0;
        end
        hit: begin
          grid_q[GW-1 -: 4] <= 4'b0000;
          if (!(&score_q)) score_q <= score_q + 1'b1;
        end
        (state == SHIFT && !(|bottom)): begin
          grid_q <= {grid_q[GW-5:0], lane_oh};
        end
        default: ;
      endcase
    end
  end

  assign wc.score = score_q;
  assign grid     = grid_q;

endmodule

// File: tb/tb_tile_game_ctrl.sv
// Directed plus randomized bench for tile_game_ctrl.
// A narrow-score twin instance exercises saturation.
module tb_tile_game_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [3:0] key = 4'b0;
  logic [1:0] rand_lane = 2'd0;
  logic       wait_done = 1'b0;
  logic [15:0] grid, grid2;
  logic        game_over, game_over2;

  int checks = 0;
  int errors = 0;

  tile_game_ctrl_if #(.SCORE_W(24)) wc ();
  tile_game_ctrl_if #(.SCORE_W(2))  wc2 ();

  assign wc.wait_done  = wait_done;
  assign wc2.wait_done = wait_done;

  tile_game_ctrl #(.NUM_ROWS(4), .SCORE_W(24)) dut (
    .clk(clk), .resetn(resetn), .start(start), .key(key),
    .rand_lane(rand_lane), .wc(wc), .grid(grid),
    .game_over(game_over)
  );

  tile_game_ctrl #(.NUM_ROWS(4), .SCORE_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .start(start), .key(key),
    .rand_lane(rand_lane), .wc(wc2), .grid(grid2),
    .game_over(game_over2)
  );

  always #5 clk = ~clk;

  // Reference model: game phase, rows as an array, hit count.
  typedef enum {M_IDLE, M_WAIT, M_SHIFT, M_OVER} mode_t;
  mode_t      m_mode;
  logic [3:0] m_rows [4];
  logic [3:0] m_kprev;
  int         m_hits;

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_kprev = 4'b0;
    m_hits  = 0;
    for (int r = 0; r < 4; r++) m_rows[r] = 4'b0;
  endtask

  task automatic model_step();
    logic [3:0] press;
    logic [3:0] bot;
    if (!resetn) begin
      model_reset();
      return;
    end
    press   = key & ~m_kprev;
    m_kprev = key;
    bot     = m_rows[3];
    case (m_mode)
      M_IDLE, M_OVER: begin
        if (start) begin
          for (int r = 0; r < 4; r++) m_rows[r] = 4'b0;
          m_hits = 0;
          m_mode = M_WAIT;
        end
      end
      M_WAIT: begin
        if (press != 0 && bot != 0) begin
          if ($countones(press) == 1 && press == bot) begin
            m_rows[3] = 4'b0;
            m_hits++;
            if (wait_done) m_mode = M_SHIFT;
          end else begin
            m_mode = M_OVER;
          end
        end else if (wait_done) begin
          m_mode = M_SHIFT;
        end
      end
      M_SHIFT: begin
        if (bot != 0) begin
          m_mode = M_OVER;
        end else begin
          for (int r = 3; r > 0; r--) m_rows[r] = m_rows[r-1];
          m_rows[0] = 4'b0001 << rand_lane;
          m_mode = M_WAIT;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] eg;
    int          sat;
    eg  = {m_rows[3], m_rows[2], m_rows[1], m_rows[0]};
    sat = (m_hits > 3) ? 3 : m_hits;
    chk({tag, ".wait_go"}, 32'(wc.wait_go), 32'(m_mode == M_WAIT));
    chk({tag, ".game_over"}, 32'(game_over), 32'(m_mode == M_OVER));
    chk({tag, ".grid"}, 32'(grid), 32'(eg));
    chk({tag, ".score"}, 32'(wc.score), 32'(m_hits));
    chk({tag, ".score_sat"}, 32'(wc2.score), 32'(sat));
    chk({tag, ".grid2"}, 32'(grid2), 32'(eg));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic shift_once(input string tag);
    wait_done = 1'b1;
    tick(tag);
    wait_done = 1'b0;
    tick(tag);
  endtask

  task automatic press_key(input logic [3:0] k, input string tag);
    key = k;
    tick(tag);
    key = 4'b0;
    tick(tag);
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset0");
    tick("reset1");
    resetn = 1'b1;
    tick("idle");

    // Fill the grid with lane-2 tiles.
    start = 1'b1;
    tick("start");
    start = 1'b0;
    chk("start.wait_go", 32'(wc.wait_go), 32'd1);
    rand_lane = 2'd2;
    for (int i = 0; i < 4; i++) shift_once("fill");
    chk("fill.grid", 32'(grid), 32'h4444);

    press_key(4'b0100, "hit");
    chk("hit.score", 32'(wc.score), 32'd1);
    chk("hit.grid", 32'(grid), 32'h0444);
    shift_once("after_hit");
    chk("after_hit.over", 32'(game_over), 32'd0);

    // Hit and wait_done together: no miss.
    key = 4'b0100;
    wait_done = 1'b1;
    tick("hit_wd");
    key = 4'b0;
    wait_done = 1'b0;
    tick("hit_wd");
    chk("hit_wd.over", 32'(game_over), 32'd0);

    // Enough hits to saturate the narrow twin.
    for (int i = 0; i < 4; i++) begin
      press_key(4'b0100, "sat");
      shift_once("sat");
    end
    chk("sat.score2", 32'(wc2.score), 32'd3);

    // start ignored in WAIT, then a double press ends the game.
    start = 1'b1;
    tick("start_wait");
    start = 1'b0;
    key = 4'b0101;
    tick("double");
    chk("double.over", 32'(game_over), 32'd1);
    key = 4'b0;
    tick("over_hold");

    // Wrong single lane.
    start = 1'b1;
    tick("restart");
    start = 1'b0;
    for (int i = 0; i < 4; i++) shift_once("fill2");
    press_key(4'b0001, "wrong");
    chk("wrong.over", 32'(game_over), 32'd1);

    // Missed tile, then restart clears the game.
    start = 1'b1;
    tick("restart2");
    start = 1'b0;
    for (int i = 0; i < 5; i++) shift_once("miss");
    chk("miss.over", 32'(game_over), 32'd1);
    start = 1'b1;
    tick("restart3");
    start = 1'b0;
    chk("restart3.grid", 32'(grid), 32'd0);
    chk("restart3.go", 32'(wc.wait_go), 32'd1);

    // Asynchronous reset in the middle of a WAIT cycle.
    shift_once("pre_rst");
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    tick("rst_hold");
    resetn = 1'b1;

    // Randomized play.
    for (int n = 0; n < 3000; n++) begin
      int r;
      start     = ($urandom_range(0, 7) == 0);
      wait_done = ($urandom_range(0, 2) == 0);
      rand_lane = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r < 5)      key = 4'b0;
      else if (r < 8) key = m_rows[3];
      else if (r < 9) key = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        resetn = 1'b0;
        #1;
        model_reset();
        check_all("rnd_rst");
        tick("rnd_rst");
        resetn = 1'b1;
      end else begin
        tick("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
